mode_key_ctrl: RTL and testbench
================================

# mode_key_ctrl

Front-panel control stage for the heartbeat LED design. It debounces two active-low push buttons and turns them into the `mode_select` and `led_select` codes that feed the pattern-driver selector directly downstream. A long press on the mode key toggles an auto-cycle demo mode, in which the pattern mode advances on a fixed period.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required before a key level is accepted (20 ms at 50 MHz).
- LONG_PRESS_CYCLES, 50_000_000: debounced hold time on the mode key that counts as a long press (1 s).
- AUTO_PERIOD, 250_000_000: cycles between automatic mode advances (5 s).
- MODE_COUNT, 4: number of valid mode codes, 0..MODE_COUNT-1; range 2..16.
- LED_COUNT, 8: number of valid LED codes, 0..LED_COUNT-1; range 2..16.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- key_mode_n  input  1  raw mode button, low = pressed, asynchronous to clk.
- key_led_n  input  1  raw LED button, low = pressed, asynchronous to clk.
- mode_select  output  4  current pattern mode code.
- led_select  output  4  current LED index code.
- auto_en  output  1  auto-cycle mode active.
- mode_changed  output  1  one-cycle pulse on every cycle in which mode_select takes a new value.

## Operation
- Each key passes through a 2-flop synchroniser, reset value 1 (released).
- Each key has its own debouncer:
  - The debounced level register resets to 1 (released).
  - A counter of width $clog2(DEBOUNCE_CYCLES+1) counts while the synchronised level differs from the debounced level. It clears to 0 on any cycle where the two levels match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- LED key: on the debounced press edge (1->0), led_select increments. Wrap rule: when led_select equals LED_COUNT-1, it returns to 0. Release does nothing.
- Mode-key FSM:
  - M_IDLE:
    - On a debounced press edge, clear the hold counter and go to M_PRESS.
  - M_PRESS:
    - The hold counter increments every cycle.
    - On debounced release, request a mode advance and go to M_IDLE.
    - When the hold counter reaches LONG_PRESS_CYCLES-1 while still pressed, toggle auto_en on that cycle and go to M_LONG.
  - M_LONG:
    - Wait for debounced release, then go to M_IDLE with no mode advance.
  - The hold counter saturates and never wraps.
- Auto-cycle:
  - While auto_en=1, the auto counter increments each cycle.
  - At AUTO_PERIOD-1, the auto counter requests a mode advance and clears to 0.
  - While auto_en=0, the auto counter is held at 0.
  - Toggling auto_en either way clears the auto counter.
- Mode advance:
  - mode_select increments with wrap: MODE_COUNT-1 -> 0.
  - A manual advance also clears the auto counter, which restarts the period.
  - A manual request and an auto request in the same cycle produce exactly one increment.
- mode_changed is registered. It is high for exactly one cycle, the same cycle mode_select shows its new value.
- Output bits above the valid range are always 0.

## Timing
- Reset values: mode_select=0, led_select=0, auto_en=0, mode_changed=0. All counters are 0 and the FSM is in M_IDLE.
- Reset mid-press: every output and all internal state return to the reset values immediately.
  - After reset release, a key that is still held sees a press edge after DEBOUNCE_CYCLES+2 cycles and is treated as a new press.
- Latency from a raw key edge to the debounced edge: DEBOUNCE_CYCLES+2 cycles.
- led_select updates 1 cycle after the debounced press edge.
- Short mode press: mode_select and mode_changed update 1 cycle after the debounced release edge.
- Long press: auto_en toggles exactly LONG_PRESS_CYCLES cycles after the debounced press edge.
- Auto advance: the first advance occurs AUTO_PERIOD cycles after auto_en rises, then every AUTO_PERIOD cycles.
- Both keys pressed at once: the keys are handled independently and both actions take effect.
- All outputs are registered. No combinational path runs from the key inputs to any output.

## Test plan
Use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, AUTO_PERIOD=10, MODE_COUNT=4, LED_COUNT=8.
- Reset: apply rst_n=0 with both keys released -> all outputs are 0. Assert reset mid-press -> all outputs are 0 immediately.
- Bounce rejection: pulse key_led_n low for 3 cycles, 5 times -> led_select stays 0. Then hold it low for 10 cycles -> led_select=1, changing 7 cycles after the falling edge.
- LED wrap: perform 9 clean LED presses -> led_select steps 1..7, 0, 1, and mode_select stays 0.
- Short mode press: hold key_mode_n low for 10 cycles, then release -> mode_select goes 0->1 only after the release, with mode_changed high for 1 cycle. Repeat 4 presses -> the sequence is 2, 3, 0, 1.
- Long press and auto: hold key_mode_n low for 40 cycles -> auto_en=1 at 20 cycles after the debounced press, with no advance on release.
  - mode_select then advances every 10 cycles.
  - Another long press -> auto_en=0 and advances stop.
- Collision: with auto_en=1, time a short mode release so its advance lands on the auto tick cycle -> a single increment, and the next auto advance comes 10 cycles later.

Source files
------------

// File: rtl/mode_key_ctrl.sv
// rtl/mode_key_ctrl.sv - debounced front-panel keys driving mode/LED select codes with auto-cycle
module mode_key_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter int AUTO_PERIOD       = 250_000_000,
    parameter int MODE_COUNT        = 4,
    parameter int LED_COUNT         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode_n,
    input  logic       key_led_n,
    output logic [3:0] mode_select,
    output logic [3:0] led_select,
    output logic       auto_en,
    output logic       mode_changed
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
    localparam int AUTO_W = $clog2(AUTO_PERIOD);

    // Counter value on the cycle that completes the required stable run.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    // Hold count one below the long-press value: the toggle cycle is the one
    // whose increment would reach LONG_PRESS_CYCLES-1.
    localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_PRESS_CYCLES - 2);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);
    localparam logic [3:0]        MODE_LAST = 4'(MODE_COUNT - 1);
    localparam logic [3:0]        LED_LAST  = 4'(LED_COUNT - 1);

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_PRESS = 2'd1,
        M_LONG  = 2'd2
    } mstate_t;

    // Index 0 is the mode key, index 1 is the LED key.
    logic [1:0]        r_sync1;
    logic [1:0]        r_sync2;
    logic [1:0]        r_db;
    logic [1:0]        r_db_prev;
    logic [DB_W-1:0]   r_db_cnt [2];

    mstate_t           r_state;
    mstate_t           w_state_next;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_next;
    logic              w_manual_adv;
    logic              w_toggle;

    logic [AUTO_W-1:0] r_auto_cnt;
    logic              r_auto_en;
    logic [3:0]        r_mode;
    logic [3:0]        r_led;
    logic              r_mode_changed;

    logic              w_mode_press;
    logic              w_mode_release;
    logic              w_led_press;
    logic              w_auto_tick;
    logic              w_advance;

    assign w_mode_press   = r_db_prev[0] & ~r_db[0];
    assign w_mode_release = ~r_db_prev[0] & r_db[0];
    assign w_led_press    = r_db_prev[1] & ~r_db[1];
    assign w_auto_tick    = r_auto_en && (r_auto_cnt == AUTO_LAST);
    assign w_advance      = w_manual_adv | w_auto_tick;

    assign mode_select  = r_mode;
    assign led_select   = r_led;
    assign auto_en      = r_auto_en;
    assign mode_changed = r_mode_changed;

    // Two-flop synchroniser for both raw keys; idle level is released (1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= {key_led_n, key_mode_n};
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: accept a new level only after an unbroken run of differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db        <= 2'b11;
            r_db_prev   <= 2'b11;
            r_db_cnt[0] <= '0;
            r_db_cnt[1] <= '0;
        end else begin
            r_db_prev <= r_db;
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_db[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_LAST) begin
                    r_db[k]     <= ~r_db[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
            end
        end
    end

    // LED index steps on each debounced press and wraps at the last valid code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 4'd0;
        end else if (w_led_press) begin
            r_led <= (r_led == LED_LAST) ? 4'd0 : r_led + 4'd1;
        end
    end

    // Mode-key FSM state and hold-time register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= M_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_next;
            r_hold  <= w_hold_next;
        end
    end

    // Mode-key FSM: short press requests an advance, long press toggles auto mode.
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        w_manual_adv = 1'b0;
        w_toggle     = 1'b0;
        case (r_state)
            M_IDLE: begin
                if (w_mode_press) begin
                    w_hold_next  = '0;
                    w_state_next = M_PRESS;
                end
            end
            M_PRESS: begin
                if (r_hold != HOLD_MAX) begin
                    w_hold_next = r_hold + 1'b1;
                end
                if (w_mode_release) begin
                    w_manual_adv = 1'b1;
                    w_state_next = M_IDLE;
                end else if (r_hold == HOLD_LONG) begin
                    w_toggle     = 1'b1;
                    w_state_next = M_LONG;
                end
            end
            M_LONG: begin
                if (w_mode_release) begin
                    w_state_next = M_IDLE;
                end
            end
            default: begin
                w_state_next = M_IDLE;
            end
        endcase
    end

    // Auto-cycle enable and period counter; any advance or toggle restarts the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_en  <= 1'b0;
            r_auto_cnt <= '0;
        end else begin
            if (w_toggle) begin
                r_auto_en <= ~r_auto_en;
            end
            if (w_toggle || w_advance || !r_auto_en) begin
                r_auto_cnt <= '0;
            end else begin
                r_auto_cnt <= r_auto_cnt + 1'b1;
            end
        end
    end

    // Mode code advances once per cycle at most, with a matching change pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode         <= 4'd0;
            r_mode_changed <= 1'b0;
        end else begin
            r_mode_changed <= w_advance;
            if (w_advance) begin
                r_mode <= (r_mode == MODE_LAST) ? 4'd0 : r_mode + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mode_key_ctrl.sv
// tb/tb_mode_key_ctrl.sv - scoreboard bench for mode_key_ctrl
module tb_mode_key_ctrl;

    localparam int D  = 4;
    localparam int L  = 20;
    localparam int A  = 10;
    localparam int MC = 4;
    localparam int LC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_mode_n = 1'b1;
    logic       key_led_n = 1'b1;
    logic [3:0] mode_select;
    logic [3:0] led_select;
    logic       auto_en;
    logic       mode_changed;

    mode_key_ctrl #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L),
        .AUTO_PERIOD      (A),
        .MODE_COUNT       (MC),
        .LED_COUNT        (LC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_mode_n  (key_mode_n),
        .key_led_n   (key_led_n),
        .mode_select (mode_select),
        .led_select  (led_select),
        .auto_en     (auto_en),
        .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t q_led[$];
    ev_t q_mode[$];
    ev_t q_auto[$];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model: event times in absolute clock-edge numbers.
    int m_led, m_mode, m_auto, m_next_tick, m_man_at, m_pressed_at, m_long_wait;
    int m_db [2];
    int hist [2][D+2];

    int p_led, p_mode, p_auto;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        n_checks++;
        n_err++;
        $display("FAIL %s_unexpected: got value %0d at cycle %0d, expected no event", name, act, cyc);
    endtask

    task automatic model_reset();
        m_led = 0; m_mode = 0; m_auto = 0; m_next_tick = -1;
        m_man_at = -1; m_pressed_at = -1; m_long_wait = 0;
        for (int k = 0; k < 2; k++) begin
            m_db[k] = 1;
            for (int i = 0; i < D + 2; i++) hist[k][i] = 1;
        end
        q_led.delete();
        q_mode.delete();
        q_auto.delete();
    endtask

    task automatic model_step();
        ev_t ev;
        bit  adv;
        bit  tog;
        bit  flip;
        int  raw;
        cyc++;
        adv = 0;
        tog = 0;
        if (m_man_at == cyc) adv = 1;
        if (m_auto != 0 && cyc == m_next_tick) adv = 1;
        if (m_pressed_at >= 0 && m_long_wait == 0 && cyc == m_pressed_at + L) begin
            tog = 1;
            m_long_wait = 1;
        end
        if (adv) begin
            m_mode = (m_mode + 1) % MC;
            ev.cyc = cyc; ev.val = m_mode;
            q_mode.push_back(ev);
            m_next_tick = cyc + A;
        end
        if (tog) begin
            m_auto = (m_auto == 0) ? 1 : 0;
            ev.cyc = cyc; ev.val = m_auto;
            q_auto.push_back(ev);
            m_next_tick = cyc + A;
        end
        // A level is accepted once D consecutive raw samples, seen through
        // the two-cycle synchroniser, all disagree with the accepted level.
        for (int k = 0; k < 2; k++) begin
            raw = (k == 0) ? int'(key_mode_n) : int'(key_led_n);
            for (int i = 0; i < D + 1; i++) hist[k][i] = hist[k][i+1];
            hist[k][D+1] = raw;
            flip = 1;
            for (int i = 0; i < D; i++) if (hist[k][i] == m_db[k]) flip = 0;
            if (flip) begin
                m_db[k] = 1 - m_db[k];
                if (k == 1 && m_db[k] == 0) begin
                    m_led = (m_led + 1) % LC;
                    ev.cyc = cyc + 1; ev.val = m_led;
                    q_led.push_back(ev);
                end
                if (k == 0 && m_db[k] == 0) begin
                    m_pressed_at = cyc;
                    m_long_wait  = 0;
                end
                if (k == 0 && m_db[k] == 1) begin
                    if (m_pressed_at >= 0 && m_long_wait == 0 && cyc <= m_pressed_at + L - 1)
                        m_man_at = cyc + 1;
                    m_pressed_at = -1;
                    m_long_wait  = 0;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Monitor: every observed output change must match the next expected event.
    initial begin
        ev_t ev;
        p_led = 0; p_mode = 0; p_auto = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_led = 0; p_mode = 0; p_auto = 0;
            end else begin
                if (int'(led_select) != p_led) begin
                    if (q_led.size() == 0) unexpected("led", int'(led_select));
                    else begin
                        ev = q_led.pop_front();
                        chk("led_cycle", cyc, ev.cyc);
                        chk("led_value", int'(led_select), ev.val);
                    end
                end
                if (mode_changed || int'(mode_select) != p_mode) begin
                    if (q_mode.size() == 0) unexpected("mode", int'(mode_select));
                    else begin
                        ev = q_mode.pop_front();
                        chk("mode_cycle", cyc, ev.cyc);
                        chk("mode_value", int'(mode_select), ev.val);
                        chk("mode_changed_pulse", int'(mode_changed), 1);
                    end
                end
                if (int'(auto_en) != p_auto) begin
                    if (q_auto.size() == 0) unexpected("auto", int'(auto_en));
                    else begin
                        ev = q_auto.pop_front();
                        chk("auto_cycle", cyc, ev.cyc);
                        chk("auto_value", int'(auto_en), ev.val);
                    end
                end
                if (q_led.size() > 0 && q_led[0].cyc < cyc) begin
                    ev = q_led.pop_front();
                    chk("led_overdue", cyc, ev.cyc);
                end
                if (q_mode.size() > 0 && q_mode[0].cyc < cyc) begin
                    ev = q_mode.pop_front();
                    chk("mode_overdue", cyc, ev.cyc);
                end
                if (q_auto.size() > 0 && q_auto[0].cyc < cyc) begin
                    ev = q_auto.pop_front();
                    chk("auto_overdue", cyc, ev.cyc);
                end
                p_led  = int'(led_select);
                p_mode = int'(mode_select);
                p_auto = int'(auto_en);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mode"}, int'(mode_select), 0);
        chk({tag, "_led"}, int'(led_select), 0);
        chk({tag, "_auto"}, int'(auto_en), 0);
        chk({tag, "_changed"}, int'(mode_changed), 0);
    endtask

    initial begin
        int c0;
        int lat;
        int bound;
        int m0;

        // Reset with keys released.
        wait_cyc(3);
        check_zero("reset");
        rst_n = 1'b1;
        wait_cyc(2);

        // Bounce rejection, then a clean hold with latency measurement.
        repeat (5) begin
            key_led_n = 1'b0; wait_cyc(3);
            key_led_n = 1'b1; wait_cyc(3);
        end
        wait_cyc(8);
        chk("bounce_led", int'(led_select), 0);
        key_led_n = 1'b0;
        c0  = cyc;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            if (lat < 0 && led_select == 4'd1) lat = cyc - c0;
        end
        key_led_n = 1'b1;
        chk("led_latency", lat, 7);
        wait_cyc(10);

        // LED wrap from a fresh reset.
        rst_n = 1'b0; wait_cyc(2);
        rst_n = 1'b1; wait_cyc(2);
        repeat (9) begin
            key_led_n = 1'b0; wait_cyc(8);
            key_led_n = 1'b1; wait_cyc(8);
        end
        chk("wrap_led", int'(led_select), 1);
        chk("wrap_mode", int'(mode_select), 0);

        // Short mode presses: advance only after release.
        key_mode_n = 1'b0; wait_cyc(10);
        chk("short_held_mode", int'(mode_select), 0);
        key_mode_n = 1'b1; wait_cyc(10);
        chk("short_mode", int'(mode_select), 1);
        repeat (4) begin
            key_mode_n = 1'b0; wait_cyc(10);
            key_mode_n = 1'b1; wait_cyc(10);
        end
        chk("short_seq_mode", int'(mode_select), 1);

        // Long press turns auto-cycle on.
        key_mode_n = 1'b0; wait_cyc(40);
        chk("long_auto_on", int'(auto_en), 1);
        key_mode_n = 1'b1; wait_cyc(35);

        // Collision: short-press advance lands on the auto tick cycle.
        key_mode_n = 1'b0; wait_cyc(6);
        bound = 0;
        while ((m_next_tick - cyc) != D + 3 && bound < 12) begin
            wait_cyc(1);
            bound++;
        end
        chk("collision_align_timeout", (bound < 12) ? 1 : 0, 1);
        m0 = m_mode;
        key_mode_n = 1'b1;
        wait_cyc(D + 3);
        chk("collision_single", int'(mode_select), (m0 + 1) % MC);
        wait_cyc(A);
        chk("collision_next_tick", int'(mode_select), (m0 + 2) % MC);
        wait_cyc(5);

        // Second long press turns auto-cycle off; advances stop.
        key_mode_n = 1'b0; wait_cyc(40);
        key_mode_n = 1'b1; wait_cyc(10);
        chk("long_auto_off", int'(auto_en), 0);
        m0 = m_mode;
        wait_cyc(30);
        chk("auto_stopped", int'(mode_select), m0);

        // Both keys at once.
        key_mode_n = 1'b0; key_led_n = 1'b0; wait_cyc(10);
        key_mode_n = 1'b1; key_led_n = 1'b1; wait_cyc(15);

        // Randomised key activity.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) key_mode_n = ~key_mode_n;
            if ($urandom_range(0, 6) == 0) key_led_n = ~key_led_n;
            wait_cyc(1);
        end
        key_mode_n = 1'b1; key_led_n = 1'b1;
        wait_cyc(40);

        // Reset mid-press; held keys are treated as new presses afterwards.
        key_mode_n = 1'b0; key_led_n = 1'b0;
        wait_cyc(12);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(40);
        key_mode_n = 1'b1; key_led_n = 1'b1;
        wait_cyc(40);

        chk("led_queue_empty", q_led.size(), 0);
        chk("mode_queue_empty", q_mode.size(), 0);
        chk("auto_queue_empty", q_auto.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
